// File: rtl/uart_tx_buffered_if.sv
// Write-side bus of uart_tx_buffered: byte strobe from the message unit plus FIFO status.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    data_in;
    logic          data_valid;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output data_in, data_valid,
        input  fifo_full, fifo_count, overflow
    );

    modport slave (
        input  data_in, data_valid,
        output fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Byte FIFO feeding an 8N1 UART transmitter; pulses eom_pulse after the stop bit of EOM_CHAR.
module uart_tx_buffered #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] EOM_CHAR     = 8'h23
) (
    input  logic              clk_50M,
    input  logic              reset,
    uart_tx_buffered_if.slave bus,
    output logic              tx,
    output logic              tx_busy,
    output logic              eom_pulse
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full_q;
    logic          ovf_q;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          is_eom;

    logic push;
    logic pop;
    logic baud_done;

    // A full FIFO drops the write even when the transmitter pops on the same edge.
    assign push      = bus.data_valid && (count != DEPTH);
    assign pop       = (state == IDLE) && (count != '0);
    assign baud_done = (baud == BAUD_LAST);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_next;
            full_q <= (count_next == DEPTH);
            if (bus.data_valid && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // tx is registered, so the wire trails the state by one cycle; every bit still lasts CLKS_PER_BIT.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            is_eom    <= 1'b0;
            tx        <= 1'b1;
            eom_pulse <= 1'b0;
        end else begin
            eom_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        is_eom <= (mem[rd_ptr] == EOM_CHAR);
                        baud   <= '0;
                        state  <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_done) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        baud      <= '0;
                        state     <= IDLE;
                        eom_pulse <= is_eom;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
            endcase
        end
    end

    assign tx_busy        = (state != IDLE);
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: edge-indexed reference model of FIFO occupancy and the expected wire.
module tb_uart_tx_buffered;
    localparam int C     = 4;
    localparam int D     = 4;
    localparam int CW    = $clog2(D) + 1;
    localparam int FRAME = 10 * C;

    logic clk_50M = 1'b0;
    logic reset;
    logic tx;
    logic tx_busy;
    logic eom_pulse;

    always #5 clk_50M = ~clk_50M;

    uart_tx_buffered_if #(.FIFO_DEPTH(D)) bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D),
        .EOM_CHAR    (8'h23)
    ) dut (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .bus      (bus.slave),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .eom_pulse(eom_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of accepted bytes, edge index t, edge of the latest pop (fs) and its byte.
    logic [7:0] q[$];
    int         t        = 0;
    int         next_pop = 0;
    int         fs       = -1000;
    logic [7:0] fb       = 8'h00;
    logic       ovf_m    = 1'b0;

    int eom_seen;
    int busy_cyc;
    int peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic exp_tx();
        int rel;
        int k;
        rel = t - fs - 1;
        if (rel < 0 || rel >= FRAME) return 1'b1;
        k = rel / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fb[k-1];
    endfunction

    function automatic logic exp_busy();
        return (t >= fs) && (t <= fs + FRAME - 1);
    endfunction

    function automatic logic exp_eom();
        return (t == fs + FRAME) && (fb == 8'h23);
    endfunction

    task automatic model_clear();
        q.delete();
        next_pop = 0;
        fs       = -1000;
        fb       = 8'h00;
        ovf_m    = 1'b0;
    endtask

    task automatic check_all();
        chk("tx", 32'(tx), 32'(exp_tx()));
        chk("tx_busy", 32'(tx_busy), 32'(exp_busy()));
        chk("eom_pulse", 32'(eom_pulse), 32'(exp_eom()));
        chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        chk("fifo_full", 32'(bus.fifo_full), 32'(q.size() == D));
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        int  pre;
        bit  accept;
        bus.data_valid = v;
        bus.data_in    = d;
        @(posedge clk_50M);
        t++;
        pre    = q.size();
        accept = v && (pre < D);
        if (v && pre == D) ovf_m = 1'b1;
        if (t >= next_pop && pre > 0) begin
            fb       = q.pop_front();
            fs       = t;
            next_pop = t + FRAME + 1;
        end
        if (accept) q.push_back(d);
        #1;
        check_all();
        if (eom_pulse === 1'b1) eom_seen++;
        if (tx_busy === 1'b1) busy_cyc++;
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        bus.data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk_50M);
            t++;
        end
        @(negedge clk_50M);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic clear_obs();
        eom_seen = 0;
        busy_cyc = 0;
        peak     = 0;
    endtask

    initial begin
        logic [7:0] msg [5];
        msg[0] = 8'h45; msg[1] = 8'h4E; msg[2] = 8'h44; msg[3] = 8'h2D; msg[4] = 8'h23;

        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        reset          = 1'b1;
        model_clear();
        #12;
        check_all();
        @(negedge clk_50M);
        reset = 1'b0;

        // Single byte 'F'
        clear_obs();
        tick(1'b1, 8'h46);
        idle(50);
        chk("single_busy_cycles", 32'(busy_cyc), 32'(FRAME));
        chk("single_eom_count", 32'(eom_seen), 32'd0);

        // "END-#" burst on consecutive cycles
        clear_obs();
        for (int i = 0; i < 5; i++) tick(1'b1, msg[i]);
        idle(5 * (FRAME + 1) + 10);
        chk("burst_peak_count", 32'(peak), 32'd4);
        chk("burst_eom_count", 32'(eom_seen), 32'd1);

        // Six strobes into a depth-4 FIFO
        do_reset();
        clear_obs();
        for (int i = 0; i < 6; i++) tick(1'b1, 8'hA0 + 8'(i));
        chk("ovf_after_6th", 32'(bus.overflow), 32'd1);
        chk("ovf_full_seen", 32'(peak), 32'(D));
        idle(6 * (FRAME + 1) + 10);

        // Strobe landing on the IDLE pop edge, then reset during data bit 3
        do_reset();
        tick(1'b1, 8'h5A);
        tick(1'b1, 8'h11);
        chk("wr_pop_count", 32'(bus.fifo_count), 32'd1);
        for (int i = 0; i < 100 && t < fs + 1 + 4 * C + 1; i++) tick(1'b0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_full", 32'(bus.fifo_full), 32'd0);
        repeat (2) begin
            @(posedge clk_50M);
            t++;
        end
        @(negedge clk_50M);
        reset = 1'b0;
        model_clear();
        tick(1'b1, 8'hC3);
        idle(50);

        // Pointer wrap: 3*D bytes in groups that never fill the FIFO
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom));
            idle(3 * (FRAME + 1) + 2);
        end
        chk("wrap_overflow", 32'(bus.overflow), 32'd0);

        // Random traffic with occasional terminators
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic [7:0] d;
            v = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 7) == 0) ? 8'h23 : 8'($urandom);
            tick(v, d);
        end
        idle((D + 1) * (FRAME + 1) + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Downstream consumer of the message unit's byte stream (msg / data_send), e.g. the "FIM-…-#" status strings.
- Buffers incoming bytes in a small FIFO and serialises each byte as 8N1 UART on the tx pin at a fixed baud derived from clk_50M.
- Flags the end of each message (terminator byte 0x23 '#') once that byte has fully left the wire.
- Isolates the message producer from serial line timing.

Parameters:
- CLKS_PER_BIT, 434, clk_50M cycles per UART bit (115200 baud at 50 MHz); benches override it to 4.
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.
- EOM_CHAR, 8'h23, terminator byte that triggers eom_pulse.

Ports:
- clk_50M  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  byte from the message unit.
- data_valid  input  1  one-cycle write strobe; data_in is sampled on the same edge.
- fifo_full  output  1  high when the FIFO holds FIFO_DEPTH entries.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of entries.
- overflow  output  1  sticky; set when a write is dropped.
- tx  output  1  UART serial line; idle high.
- tx_busy  output  1  high while a frame is on the wire (states START, DATA and STOP).
- eom_pulse  output  1  one-cycle pulse after the stop bit of an EOM_CHAR frame.

Behaviour:
- Clock and reset: one clock, clk_50M. reset is asynchronous and active-high and forces all state immediately.
- Reset values: tx=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, eom_pulse=0; FIFO pointers 0; FSM=IDLE; bit and baud counters 0.
- Reset mid-frame: the frame aborts, tx returns to 1 at once, and FIFO contents are discarded.
- FIFO write: on data_valid=1, the byte is written if the pre-edge count < FIFO_DEPTH.
- FIFO full: if the pre-edge count is FIFO_DEPTH, the byte is dropped, overflow is set, and overflow stays set until reset. This holds even if a pop occurs on the same edge.
- Simultaneous write and pop with count not full: count is unchanged and both operations take effect.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_full is (count == FIFO_DEPTH), registered from the updated count.
- FSM IDLE: tx=1. If count > 0, pop the head into an 8-bit shift register, latch is_eom = (head == EOM_CHAR), clear the baud counter, and go to START.
- FSM START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- FSM DATA: tx = shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7 completes, go to STOP.
- FSM STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. On that same edge, eom_pulse=1 for exactly one cycle if is_eom is set.
- Latency: a strobe into an empty, idle block lands on edge N. IDLE pops on edge N+1. tx falls on edge N+2.
- Frame period: back-to-back frames occupy 10*CLKS_PER_BIT + 1 cycles, including one IDLE cycle of tx=1 between the stop bit and the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 with a width sufficient for CLKS_PER_BIT-1. The terminal count advances the state or bit index.
- Byte filtering: none. Byte 8'h00 is transmitted like any other byte.

Test Plan:
- Single byte (CLKS_PER_BIT=4): one strobe with 8'h46 -> tx low 2 cycles after the strobe edge. Wire bits are 0,0,1,1,0,0,0,1,0,1 with 4 cycles each. tx_busy is high for 40 cycles. eom_pulse stays 0.
- Message burst: strobe "END-#" (0x45,0x4E,0x44,0x2D,0x23) on consecutive cycles -> fifo_count peaks at 4. Five frames are sent with 41-cycle spacing. eom_pulse fires once, on the final STOP-exit edge.
- Overflow (FIFO_DEPTH=4): 6 strobes in 6 cycles -> fifo_full asserts. overflow sets on the 6th strobe. The 5 accepted bytes are transmitted in order and the 6th never appears.
- Write and pop same edge: a strobe lands while IDLE pops with count=1 -> count stays 1 and the new byte is the next frame sent.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1, tx_busy=0 and count=0 immediately, with no edge needed. After release and a new strobe, a clean frame is sent.
- Pointer wrap: send 3*FIFO_DEPTH bytes, paced so the FIFO never fills -> all bytes arrive in order and overflow stays 0.
